// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the main-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_LDR = 1'b1;

  // Wide enough for LAT-1 and STARVE_MAX over their 1..15 range.
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// Winner select between CPU and loader, with a saturating starvation counter
// that forces the loader through after STARVE_MAX consecutive CPU wins.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic cpu_req,
  input  logic ldr_req,
  input  logic grant_strobe,
  output logic pick_ldr,
  output logic grant_valid
);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  always_comb begin
    starved     = (starve_cnt == CNT_W'(STARVE_MAX));
    grant_valid = cpu_req | ldr_req;
    pick_ldr    = ldr_req & (~cpu_req | starved);
  end

  // Only CPU wins over a waiting loader accumulate; anything else resets the run.
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_cnt <= '0;
    end else if (grant_strobe) begin
      if (pick_ldr || !ldr_req) begin
        starve_cnt <= '0;
      end else if (!starved) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port main memory between the CPU memory path and the
// loader/debug port: fixed-latency access, one-cycle ack, CPU priority.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned LAT        = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  output logic [DW-1:0] ldr_rdata,
  output logic          ldr_ack,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lat_we;
  logic [AW-1:0]    lat_addr;
  logic [DW-1:0]    lat_wdata;
  logic             owner_q;
  logic [DW-1:0]    cpu_rdata_q;
  logic [DW-1:0]    ldr_rdata_q;
  logic             pick_ldr;
  logic             grant_valid;
  logic             grant_strobe;

  assign grant_strobe = (state == IDLE) && grant_valid;

  arb_pick #(
    .STARVE_MAX(STARVE_MAX)
  ) u_pick (
    .clk         (clk),
    .reset       (reset),
    .cpu_req     (cpu_req),
    .ldr_req     (ldr_req),
    .grant_strobe(grant_strobe),
    .pick_ldr    (pick_ldr),
    .grant_valid (grant_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_we      <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      owner_q     <= OWN_CPU;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner_q   <= pick_ldr ? OWN_LDR : OWN_CPU;
            lat_we    <= pick_ldr ? ldr_we : cpu_we;
            lat_addr  <= pick_ldr ? ldr_addr : cpu_addr;
            lat_wdata <= pick_ldr ? ldr_wdata : cpu_wdata;
            cnt       <= CNT_W'(LAT - 1);
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == '0) begin
            if (!lat_we) begin
              if (owner_q == OWN_LDR) ldr_rdata_q <= mem_rdata;
              else                    cpu_rdata_q <= mem_rdata;
            end
            state <= DONE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_en    = (state == ACCESS);
    mem_we    = (state == ACCESS) && lat_we;
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    cpu_ack   = (state == DONE) && (owner_q == OWN_CPU);
    ldr_ack   = (state == DONE) && (owner_q == OWN_LDR);
    cpu_rdata = cpu_rdata_q;
    ldr_rdata = ldr_rdata_q;
    busy      = (state != IDLE);
    owner     = owner_q;
  end

endmodule
